fp_convert_pipe: RTL

- Pipelined, parametrised converter from IN_W-bit two's-complement integers to a compact float of {sign, EXP_W-bit exponent, MAN_W-bit significand}.
- Encoded value is (-1)^S * F * 2^E.
- Successor to the combinational 12-bit converter. Adds generic widths, a 3-stage registered pipeline, a valid/ready handshake with backpressure, and a saturation flag.
- Sits between a sample source and the display/packing logic.

---
 rtl/fp_conv_pkg.sv | 39 +++
 rtl/fp_lzc.sv | 27 ++
 rtl/fp_convert_pipe.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/fp_conv_pkg.sv
// rtl/fp_conv_pkg.sv - shared widths, helpers and round-mode selection for fp_convert_pipe
// Build option: FP_CONVERT_ROUND_NEAREST_EVEN_EN selects round-half-even; otherwise round-half-up.
package fp_conv_pkg;

    localparam int DEF_IN_W  = 12;
    localparam int DEF_EXP_W = 3;
    localparam int DEF_MAN_W = 4;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int e_max(input int exp_w);
        return (1 << exp_w) - 1;
    endfunction

    // Every magnitude bit above the significand must be reachable by the exponent.
    function automatic bit cfg_legal(input int in_w, input int exp_w, input int man_w);
        return (in_w - 1) <= (man_w + e_max(exp_w));
    endfunction

    localparam int DEF_E_MAX     = e_max(DEF_EXP_W);
    localparam bit DEF_CFG_LEGAL = cfg_legal(DEF_IN_W, DEF_EXP_W, DEF_MAN_W);

`ifdef FP_CONVERT_ROUND_NEAREST_EVEN_EN
    localparam bit ROUND_NEAREST_EVEN = 1'b1;
`else
    localparam bit ROUND_NEAREST_EVEN = 1'b0;
`endif

endpackage

// File: rtl/fp_lzc.sv
// rtl/fp_lzc.sv - combinational leading-zero counter
// Ports: data_i [W-1:0] word to scan; count_o [clog2(W+1)-1:0] leading zeros (W when data_i is 0).
module fp_lzc
    import fp_conv_pkg::*;
#(
    parameter int W = 11,
    localparam int CNT_W = clog2(W + 1)
) (
    input  logic [W-1:0]     data_i,
    output logic [CNT_W-1:0] count_o
);

    int count;

    // Later (higher) set bits overwrite earlier ones, so the MSB-most one wins.
    always_comb begin
        count = W;
        for (int i = 0; i < W; i++) begin
            if (data_i[i]) begin
                count = W - 1 - i;
            end
        end
    end

    assign count_o = CNT_W'(count);

endmodule

// File: rtl/fp_convert_pipe.sv
// rtl/fp_convert_pipe.sv - 3-stage pipelined integer to compact-float converter
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_data input stream;
//        out_valid/out_ready output stream carrying out_s, out_e, out_f, out_sat.
// Build option: FP_CONVERT_ROUND_NEAREST_EVEN_EN (see fp_conv_pkg) selects tie rounding.
module fp_convert_pipe
    import fp_conv_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_s,
    output logic [EXP_W-1:0] out_e,
    output logic [MAN_W-1:0] out_f,
    output logic             out_sat
);

    localparam int M_W        = IN_W - 1;
    localparam int LZ_W       = clog2(M_W + 1);
    localparam int E_MAX      = e_max(EXP_W);
    localparam int SHIFT_BASE = M_W - MAN_W;
    localparam int X_W        = (M_W > MAN_W) ? M_W : MAN_W;

    localparam logic [IN_W-1:0]  MOST_NEG = {1'b1, {(IN_W-1){1'b0}}};
    localparam logic [MAN_W-1:0] F_MSB    = MAN_W'(1) << (MAN_W - 1);
    localparam logic [EXP_W-1:0] E_TOP    = EXP_W'(E_MAX);

    if (!cfg_legal(IN_W, EXP_W, MAN_W)) begin : g_illegal
        $error("fp_convert_pipe: IN_W-1 must not exceed MAN_W + 2**EXP_W - 1");
    end

    logic en;

    logic             s1_valid_q, s1_valid_d, s1_s_q, s1_s_d, s1_fsat_q, s1_fsat_d;
    logic [M_W-1:0]   s1_m_q, s1_m_d;
    logic [IN_W-1:0]  neg_data;

    logic             s2_valid_q, s2_valid_d, s2_s_q, s2_s_d, s2_fsat_q, s2_fsat_d;
    logic             s2_g_q, s2_g_d, s2_sticky_q, s2_sticky_d;
    logic [EXP_W-1:0] s2_e0_q, s2_e0_d;
    logic [MAN_W-1:0] s2_f0_q, s2_f0_d;
    logic [LZ_W-1:0]  lz;
    logic [X_W-1:0]   m_shifted;
    int               shamt;

    logic             out_valid_q, out_valid_d, out_s_q, out_s_d, out_sat_q, out_sat_d;
    logic [EXP_W-1:0] out_e_q, out_e_d;
    logic [MAN_W-1:0] out_f_q, out_f_d;
    logic             round_up;

    // The whole pipe moves as one; bubbles are kept rather than squeezed out.
    assign en       = out_ready | ~out_valid_q;
    assign in_ready = en;

    // Stage 1: sign/magnitude. The most-negative word has no positive twin in M_W bits.
    always_comb begin
        neg_data   = -in_data;
        s1_valid_d = in_valid;
        s1_s_d     = in_data[IN_W-1];
        s1_fsat_d  = (in_data == MOST_NEG);
        if (s1_fsat_d) begin
            s1_m_d = '1;
        end else if (s1_s_d) begin
            s1_m_d = neg_data[M_W-1:0];
        end else begin
            s1_m_d = in_data[M_W-1:0];
        end
    end

    fp_lzc #(.W(M_W)) u_lzc (
        .data_i  (s1_m_q),
        .count_o (lz)
    );

    // Stage 2: normalise so the significand holds the top MAN_W magnitude bits.
    always_comb begin
        s2_valid_d  = s1_valid_q;
        s2_s_d      = s1_s_q;
        s2_fsat_d   = s1_fsat_q;
        shamt       = SHIFT_BASE - int'(lz);
        if (shamt < 0) begin
            shamt = 0;
        end
        s2_e0_d     = EXP_W'(shamt);
        m_shifted   = X_W'(s1_m_q) >> shamt;
        s2_f0_d     = m_shifted[MAN_W-1:0];
        s2_g_d      = 1'b0;
        s2_sticky_d = 1'b0;
        for (int i = 0; i < M_W; i++) begin
            if (i == shamt - 1) begin
                s2_g_d = s1_m_q[i];
            end
            if (i < shamt - 1) begin
                s2_sticky_d = s2_sticky_d | s1_m_q[i];
            end
        end
    end

    // Stage 3: round; a carry out of the significand bumps the exponent or saturates.
    always_comb begin
        out_valid_d = s2_valid_q;
        out_s_d     = s2_s_q;
        out_e_d     = s2_e0_q;
        out_f_d     = s2_f0_q;
        out_sat_d   = 1'b0;
        round_up    = ROUND_NEAREST_EVEN ? (s2_g_q & (s2_sticky_q | s2_f0_q[0])) : s2_g_q;
        if (round_up) begin
            if (&s2_f0_q) begin
                if (s2_e0_q == E_TOP) begin
                    out_f_d   = '1;
                    out_sat_d = 1'b1;
                end else begin
                    out_f_d = F_MSB;
                    out_e_d = s2_e0_q + EXP_W'(1);
                end
            end else begin
                out_f_d = s2_f0_q + MAN_W'(1);
            end
        end
        if (s2_fsat_q) begin
            out_e_d   = E_TOP;
            out_f_d   = '1;
            out_sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_s_q      <= 1'b0;
            s1_fsat_q   <= 1'b0;
            s1_m_q      <= '0;
            s2_valid_q  <= 1'b0;
            s2_s_q      <= 1'b0;
            s2_fsat_q   <= 1'b0;
            s2_g_q      <= 1'b0;
            s2_sticky_q <= 1'b0;
            s2_e0_q     <= '0;
            s2_f0_q     <= '0;
            out_valid_q <= 1'b0;
            out_s_q     <= 1'b0;
            out_e_q     <= '0;
            out_f_q     <= '0;
            out_sat_q   <= 1'b0;
        end else if (en) begin
            s1_valid_q  <= s1_valid_d;
            s1_s_q      <= s1_s_d;
            s1_fsat_q   <= s1_fsat_d;
            s1_m_q      <= s1_m_d;
            s2_valid_q  <= s2_valid_d;
            s2_s_q      <= s2_s_d;
            s2_fsat_q   <= s2_fsat_d;
            s2_g_q      <= s2_g_d;
            s2_sticky_q <= s2_sticky_d;
            s2_e0_q     <= s2_e0_d;
            s2_f0_q     <= s2_f0_d;
            out_valid_q <= out_valid_d;
            out_s_q     <= out_s_d;
            out_e_q     <= out_e_d;
            out_f_q     <= out_f_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_s     = out_s_q;
    assign out_e     = out_e_q;
    assign out_f     = out_f_q;
    assign out_sat   = out_sat_q;

endmodule
